big_core_mem_arb: RTL and testbench
===================================

Name: big_core_mem_arb

Overview:
- Two-requester arbiter that shares the single data-memory port between the big_core data path (requester 0, "core") and a host/debug loader (requester 1, "host").
- Grants at most one access per cycle and drives the granted request onto the memory port.
- Tracks outstanding reads in a latency pipeline and routes each read response back to the requester that issued it.
- Sits between the core's DMem interface and the data memory instance in the core top.

Parameters:
- RD_LATENCY, 1, cycles from MemRdEn asserted to MemRspData valid; legal range 1..4.
- LOCK_MAX, 8, maximum consecutive host grants under HostLock before the core is forced one grant.

Ports:
- Clk  in  1  core clock.
- Rst  in  1  synchronous reset, active-high.
- CoreReq  in  1  core request valid.
- CoreAddr  in  32  byte address.
- CoreWrData  in  32  store data.
- CoreByteEn  in  4  byte enables.
- CoreWrEn  in  1  1=write, 0=read.
- CoreReady  out  1  request accepted this cycle.
- CoreRspVld  out  1  read data valid.
- CoreRspData  out  32  read data.
- HostReq, HostAddr, HostWrData, HostByteEn, HostWrEn, HostReady, HostRspVld, HostRspData: same widths and meaning as the Core* ports, for the host.
- HostLock  in  1  host requests back-to-back priority (atomic sequence).
- MemAddress  out  32  memory address.
- MemData  out  32  memory write data.
- MemByteEn  out  4  memory byte enables.
- MemWrEn  out  1  memory write strobe.
- MemRdEn  out  1  memory read strobe.
- MemRspData  in  32  memory read data, valid RD_LATENCY cycles after MemRdEn.

Behaviour:
- Clocking/reset: one clock (Clk); reset (Rst) is synchronous and active-high. All state updates on posedge Clk.
- Reset values:
  - LastGnt = host, so the core wins the first conflict.
  - Lock counter = 0.
  - Tag pipeline cleared.
  - CoreRspVld = HostRspVld = 0.
  - While Rst=1: CoreReady, HostReady, MemWrEn and MemRdEn are forced 0.
- Grant (combinational, same cycle):
  - Only one requester active: it is granted.
  - Both active: the requester not equal to LastGnt is granted (round-robin).
  - Lock override: if HostLock=1, LastGnt=host and lock counter < LOCK_MAX, the host is granted.
  - No request: no grant.
- Ready: XReady = grant to X. A request is accepted only when XReq && XReady. Requesters hold their request stable until Ready.
- Memory drive:
  - Granted request's Addr, WrData and ByteEn are driven to the Mem* outputs.
  - MemWrEn = granted && WrEn; MemRdEn = granted && !WrEn.
  - With no grant, all Mem* outputs are 0.
- LastGnt: updates to the granted id on every grant; holds otherwise.
- Lock counter:
  - Increments on each host grant while HostLock=1.
  - Clears on any core grant or when HostLock=0.
  - At LOCK_MAX with the core requesting, the core is granted for exactly 1 cycle, then the counter clears.
  - Saturates at LOCK_MAX.
- Read tag pipeline:
  - Shift register of depth RD_LATENCY carrying {vld, id}.
  - Stage 0 loads {MemRdEn, granted id} each cycle.
  - At the last stage: if vld, RspVld of the matching id = 1 for one cycle; RspData of both requesters = MemRspData.
  - Writes produce no response.
  - Throughput is one access per cycle; reads from both requesters can be in flight interleaved.
- Simultaneous events: a grant in cycle N and a response for an older read in cycle N are independent; no stall.
- Reset mid-operation: in-flight tags are discarded; no RspVld is generated for reads issued before reset.

Decomposition:
- big_core_pkg additions: t_arb_id enum (ARB_CORE=1'b0, ARB_HOST=1'b1); t_mem_req struct {addr, wr_data, byte_en, wr_en}.
- Sub-module: big_core_rsp_tag_pipe, the RD_LATENCY-deep {vld, id} shift register, reusable for the instruction-memory side later.

Test Plan:
- Core only: CoreReq read at addr 0x100 in cycle 0, RD_LATENCY=1 -> CoreReady=1, MemRdEn=1, MemAddress=0x100 in cycle 0; CoreRspVld=1 with CoreRspData=MemRspData in cycle 1; HostRspVld stays 0.
- Both request continuously, HostLock=0 -> grants alternate core, host, core, host…; after reset the core wins first.
- HostLock=1, both request, LOCK_MAX=8 -> 8 consecutive host grants, then 1 core grant, then host resumes.
- Interleaved reads, RD_LATENCY=3: core read, host read, core write on consecutive cycles -> responses arrive at cycles 3 and 4 tagged core then host; no response for the write; SW with ByteEn=4'b1111 seen on MemWrEn.
- Reset asserted one cycle after a read grant with RD_LATENCY=2 -> no RspVld on either requester; Ready and Mem enables are 0 during reset.
- Idle: no requests -> all Mem* outputs 0 and LastGnt unchanged (checked by the next conflict's winner).

Source files
------------

// File: rtl/big_core_pkg.sv
// Shared types for the big_core memory-side blocks: requester ids and the
// request bundle driven onto a memory port.
package big_core_pkg;

    typedef enum logic {
        ARB_CORE = 1'b0,
        ARB_HOST = 1'b1
    } t_arb_id;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wr_data;
        logic [3:0]  byte_en;
        logic        wr_en;
    } t_mem_req;

endpackage

// File: rtl/big_core_rsp_tag_pipe.sv
// Fixed-latency {vld, id} shift register that remembers who issued each read,
// so the response can be steered back when the memory data arrives.
module big_core_rsp_tag_pipe
    import big_core_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vld_i,
    input  logic id_i,
    output logic vld_o,
    output logic id_o
);

    typedef struct packed {
        logic    vld;
        t_arb_id id;
    } t_tag;

    t_tag tag_q [Depth];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: vld_i, id: t_arb_id'(id_i)};
            for (int unsigned i = 1; i < Depth; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign vld_o = tag_q[Depth-1].vld;
    assign id_o  = tag_q[Depth-1].id;

endmodule

// File: rtl/big_core_mem_arb.sv
// Core/host arbiter for the shared data-memory port: round-robin grant with a
// bounded host lock, plus read-response steering through a tag pipeline.
module big_core_mem_arb
    import big_core_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned LOCK_MAX   = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        CoreReq,
    input  logic [31:0] CoreAddr,
    input  logic [31:0] CoreWrData,
    input  logic [3:0]  CoreByteEn,
    input  logic        CoreWrEn,
    output logic        CoreReady,
    output logic        CoreRspVld,
    output logic [31:0] CoreRspData,
    input  logic        HostReq,
    input  logic [31:0] HostAddr,
    input  logic [31:0] HostWrData,
    input  logic [3:0]  HostByteEn,
    input  logic        HostWrEn,
    output logic        HostReady,
    output logic        HostRspVld,
    output logic [31:0] HostRspData,
    input  logic        HostLock,
    output logic [31:0] MemAddress,
    output logic [31:0] MemData,
    output logic [3:0]  MemByteEn,
    output logic        MemWrEn,
    output logic        MemRdEn,
    input  logic [31:0] MemRspData
);

    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
    localparam logic [CntW-1:0] LockMax = CntW'(LOCK_MAX);

    t_arb_id         last_gnt_q, last_gnt_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            core_gnt, host_gnt;
    t_arb_id         gnt_id;
    t_mem_req        core_req, host_req, mem_req;
    logic            tag_vld, tag_id;

    // Lock only extends a host streak; once it hits LockMax the core gets one slot.
    always_comb begin
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        if (!Rst) begin
            if (CoreReq && HostReq) begin
                if (HostLock && last_gnt_q == ARB_HOST && lock_cnt_q < LockMax) begin
                    host_gnt = 1'b1;
                end else if (last_gnt_q == ARB_HOST) begin
                    core_gnt = 1'b1;
                end else begin
                    host_gnt = 1'b1;
                end
            end else begin
                core_gnt = CoreReq;
                host_gnt = HostReq;
            end
        end
    end

    assign gnt_id    = host_gnt ? ARB_HOST : ARB_CORE;
    assign CoreReady = core_gnt;
    assign HostReady = host_gnt;

    assign core_req = '{addr: CoreAddr, wr_data: CoreWrData, byte_en: CoreByteEn,
                        wr_en: CoreWrEn};
    assign host_req = '{addr: HostAddr, wr_data: HostWrData, byte_en: HostByteEn,
                        wr_en: HostWrEn};

    always_comb begin
        mem_req = '0;
        if (core_gnt) begin
            mem_req = core_req;
        end else if (host_gnt) begin
            mem_req = host_req;
        end
    end

    assign MemAddress = mem_req.addr;
    assign MemData    = mem_req.wr_data;
    assign MemByteEn  = mem_req.byte_en;
    assign MemWrEn    = mem_req.wr_en;
    assign MemRdEn    = (core_gnt || host_gnt) && !mem_req.wr_en;

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (core_gnt || host_gnt) begin
            last_gnt_d = gnt_id;
        end
        lock_cnt_d = lock_cnt_q;
        if (!HostLock || core_gnt) begin
            lock_cnt_d = '0;
        end else if (host_gnt && lock_cnt_q != LockMax) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            last_gnt_q <= ARB_HOST;
            lock_cnt_q <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    big_core_rsp_tag_pipe #(
        .Depth (RD_LATENCY)
    ) u_tag_pipe (
        .clk_i (Clk),
        .rst_i (Rst),
        .vld_i (MemRdEn),
        .id_i  (gnt_id),
        .vld_o (tag_vld),
        .id_o  (tag_id)
    );

    // Gate with Rst so a response landing in the reset cycle itself is dropped.
    assign CoreRspVld  = !Rst && tag_vld && (tag_id == ARB_CORE);
    assign HostRspVld  = !Rst && tag_vld && (tag_id == ARB_HOST);
    assign CoreRspData = MemRspData;
    assign HostRspData = MemRspData;

endmodule

// File: tb/tb_big_core_mem_arb.sv
// Bench for big_core_mem_arb: directed table, lock sequence and random traffic,
// run on a latency-1 and a latency-3 instance against a cycle-history model.
module tb_big_core_mem_arb;

    localparam int unsigned LockMax = 8;
    localparam int unsigned HistN   = 4096;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst, CoreReq, CoreWrEn, HostReq, HostWrEn, HostLock;
    logic [31:0] CoreAddr, CoreWrData, HostAddr, HostWrData, MemRspData;
    logic [3:0]  CoreByteEn, HostByteEn;

    logic        c_rdy1, h_rdy1, c_vld1, h_vld1, mwe1, mre1;
    logic [31:0] c_dat1, h_dat1, maddr1, mdata1;
    logic [3:0]  mbe1;
    logic        c_rdy3, h_rdy3, c_vld3, h_vld3, mwe3, mre3;
    logic [31:0] c_dat3, h_dat3, maddr3, mdata3;
    logic [3:0]  mbe3;

    big_core_mem_arb #(.RD_LATENCY(1), .LOCK_MAX(LockMax)) dut_l1 (
        .Clk(Clk), .Rst(Rst),
        .CoreReq(CoreReq), .CoreAddr(CoreAddr), .CoreWrData(CoreWrData),
        .CoreByteEn(CoreByteEn), .CoreWrEn(CoreWrEn), .CoreReady(c_rdy1),
        .CoreRspVld(c_vld1), .CoreRspData(c_dat1),
        .HostReq(HostReq), .HostAddr(HostAddr), .HostWrData(HostWrData),
        .HostByteEn(HostByteEn), .HostWrEn(HostWrEn), .HostReady(h_rdy1),
        .HostRspVld(h_vld1), .HostRspData(h_dat1), .HostLock(HostLock),
        .MemAddress(maddr1), .MemData(mdata1), .MemByteEn(mbe1),
        .MemWrEn(mwe1), .MemRdEn(mre1), .MemRspData(MemRspData)
    );

    big_core_mem_arb #(.RD_LATENCY(3), .LOCK_MAX(LockMax)) dut_l3 (
        .Clk(Clk), .Rst(Rst),
        .CoreReq(CoreReq), .CoreAddr(CoreAddr), .CoreWrData(CoreWrData),
        .CoreByteEn(CoreByteEn), .CoreWrEn(CoreWrEn), .CoreReady(c_rdy3),
        .CoreRspVld(c_vld3), .CoreRspData(c_dat3),
        .HostReq(HostReq), .HostAddr(HostAddr), .HostWrData(HostWrData),
        .HostByteEn(HostByteEn), .HostWrEn(HostWrEn), .HostReady(h_rdy3),
        .HostRspVld(h_vld3), .HostRspData(h_dat3), .HostLock(HostLock),
        .MemAddress(maddr3), .MemData(mdata3), .MemByteEn(mbe3),
        .MemWrEn(mwe3), .MemRdEn(mre3), .MemRspData(MemRspData)
    );

    typedef struct {
        logic        rst, creq, cwe, hreq, hwe, hlock;
        logic [31:0] caddr, haddr;
        logic        e_crdy, e_hrdy, e_rd, e_wr;
        logic [31:0] e_addr;
        logic        e_c1, e_h1, e_c3, e_h3;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned m_last = 1;   // 0 = core, 1 = host
    int unsigned m_lock = 0;   // consecutive host grants under lock
    bit          hv [HistN];   // read issued in that cycle
    bit          hid [HistN];  // issuer of that read (1 = host)
    bit          g_core, g_host;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    function automatic logic exp_rsp(input int unsigned lat, input bit id);
        if (Rst || cyc < lat) return 1'b0;
        return hv[cyc-lat] && (hid[cyc-lat] == id);
    endfunction

    function automatic vec_t mk(input int rst, input int creq, input int cwe, input int ca,
                                input int hreq, input int hwe, input int ha, input int lk,
                                input int crdy, input int hrdy, input int rd, input int wr,
                                input int ea, input int c1, input int h1, input int c3,
                                input int h3);
        vec_t v;
        v.rst = rst[0]; v.creq = creq[0]; v.cwe = cwe[0]; v.caddr = 32'(ca);
        v.hreq = hreq[0]; v.hwe = hwe[0]; v.haddr = 32'(ha); v.hlock = lk[0];
        v.e_crdy = crdy[0]; v.e_hrdy = hrdy[0]; v.e_rd = rd[0]; v.e_wr = wr[0];
        v.e_addr = 32'(ea);
        v.e_c1 = c1[0]; v.e_h1 = h1[0]; v.e_c3 = c3[0]; v.e_h3 = h3[0];
        return v;
    endfunction

    // mode 0: model only, 1: full table row, 2: grant bits of v only
    task automatic step(input int mode, input vec_t v);
        logic [31:0] e_addr, e_data;
        logic [3:0]  e_be;
        logic        e_we, e_re;
        MemRspData = $urandom();
        g_core = 1'b0;
        g_host = 1'b0;
        if (!Rst) begin
            if (CoreReq && HostReq) begin
                if (HostLock && m_last == 1 && m_lock < LockMax) g_host = 1'b1;
                else if (m_last == 1) g_core = 1'b1;
                else g_host = 1'b1;
            end else begin
                g_core = CoreReq;
                g_host = HostReq;
            end
        end
        e_addr = g_core ? CoreAddr : (g_host ? HostAddr : 32'h0);
        e_data = g_core ? CoreWrData : (g_host ? HostWrData : 32'h0);
        e_be   = g_core ? CoreByteEn : (g_host ? HostByteEn : 4'h0);
        e_we   = g_core ? CoreWrEn : (g_host ? HostWrEn : 1'b0);
        e_re   = (g_core || g_host) && !e_we;

        @(negedge Clk);
        chk1("core_ready", c_rdy1, g_core);
        chk1("host_ready", h_rdy1, g_host);
        chk32("mem_addr", maddr1, e_addr);
        chk32("mem_data", mdata1, e_data);
        chk32("mem_be", {28'h0, mbe1}, {28'h0, e_be});
        chk1("mem_wr", mwe1, e_we);
        chk1("mem_rd", mre1, e_re);
        chk32("l3_mem", {maddr3 ^ mdata3, mbe3, mwe3, mre3, c_rdy3, h_rdy3},
              {e_addr ^ e_data, e_be, e_we, e_re, g_core, g_host});
        chk1("l1_core_rsp", c_vld1, exp_rsp(1, 1'b0));
        chk1("l1_host_rsp", h_vld1, exp_rsp(1, 1'b1));
        chk1("l3_core_rsp", c_vld3, exp_rsp(3, 1'b0));
        chk1("l3_host_rsp", h_vld3, exp_rsp(3, 1'b1));
        chk32("rsp_data", c_dat1 ^ h_dat3, 32'h0);
        chk32("rsp_data_src", h_dat1, MemRspData);
        if (mode != 0) begin
            chk1("tv_core_ready", c_rdy1, v.e_crdy);
            chk1("tv_host_ready", h_rdy1, v.e_hrdy);
        end
        if (mode == 1) begin
            chk1("tv_mem_rd", mre1, v.e_rd);
            chk1("tv_mem_wr", mwe1, v.e_wr);
            chk32("tv_mem_addr", maddr1, v.e_addr);
            chk1("tv_l1_core_rsp", c_vld1, v.e_c1);
            chk1("tv_l1_host_rsp", h_vld1, v.e_h1);
            chk1("tv_l3_core_rsp", c_vld3, v.e_c3);
            chk1("tv_l3_host_rsp", h_vld3, v.e_h3);
        end

        @(posedge Clk);
        if (Rst) begin
            m_last = 1;
            m_lock = 0;
            for (int unsigned i = 0; i <= cyc; i++) hv[i] = 1'b0;
        end else begin
            if (g_core) m_last = 0;
            else if (g_host) m_last = 1;
            if (!HostLock || g_core) m_lock = 0;
            else if (g_host && m_lock < LockMax) m_lock++;
            hv[cyc]  = e_re;
            hid[cyc] = g_host;
        end
        cyc++;
        #1;
    endtask

    vec_t tv [22];
    vec_t vz;
    bit   c_held, h_held;

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        //            rst cq cw caddr  hq hw haddr  lk | cr hr rd wr addr   c1 h1 c3 h3
        tv[0]  = mk(1, 1, 0, 'h100, 1, 0, 'h300, 0,  0, 0, 0, 0, 'h000,  0, 0, 0, 0);
        tv[1]  = mk(0, 1, 0, 'h100, 0, 0, 'h000, 0,  1, 0, 1, 0, 'h100,  0, 0, 0, 0);
        tv[2]  = mk(0, 0, 0, 'h000, 0, 0, 'h000, 0,  0, 0, 0, 0, 'h000,  1, 0, 0, 0);
        tv[3]  = mk(0, 1, 0, 'h200, 1, 0, 'h300, 0,  0, 1, 1, 0, 'h300,  0, 0, 0, 0);
        tv[4]  = mk(0, 1, 0, 'h200, 1, 0, 'h304, 0,  1, 0, 1, 0, 'h200,  0, 1, 1, 0);
        tv[5]  = mk(0, 0, 0, 'h000, 1, 0, 'h304, 0,  0, 1, 1, 0, 'h304,  1, 0, 0, 0);
        tv[6]  = mk(0, 0, 0, 'h000, 0, 0, 'h000, 0,  0, 0, 0, 0, 'h000,  0, 1, 0, 1);
        tv[7]  = mk(0, 1, 0, 'h500, 1, 0, 'h600, 0,  1, 0, 1, 0, 'h500,  0, 0, 1, 0);
        tv[8]  = mk(0, 0, 0, 'h000, 1, 0, 'h600, 0,  0, 1, 1, 0, 'h600,  1, 0, 0, 1);
        tv[9]  = mk(0, 1, 1, 'h700, 0, 0, 'h000, 0,  1, 0, 0, 1, 'h700,  0, 1, 0, 0);
        tv[10] = mk(0, 0, 0, 'h000, 0, 0, 'h000, 0,  0, 0, 0, 0, 'h000,  0, 0, 1, 0);
        tv[11] = mk(0, 0, 0, 'h000, 0, 0, 'h000, 0,  0, 0, 0, 0, 'h000,  0, 0, 0, 1);
        tv[12] = mk(0, 0, 0, 'h000, 0, 0, 'h000, 0,  0, 0, 0, 0, 'h000,  0, 0, 0, 0);
        tv[13] = mk(0, 1, 0, 'h800, 0, 0, 'h000, 0,  1, 0, 1, 0, 'h800,  0, 0, 0, 0);
        tv[14] = mk(1, 1, 0, 'h804, 1, 1, 'h880, 0,  0, 0, 0, 0, 'h000,  0, 0, 0, 0);
        tv[15] = mk(0, 0, 0, 'h000, 0, 0, 'h000, 0,  0, 0, 0, 0, 'h000,  0, 0, 0, 0);
        tv[16] = mk(0, 0, 0, 'h000, 0, 0, 'h000, 0,  0, 0, 0, 0, 'h000,  0, 0, 0, 0);
        tv[17] = mk(0, 1, 0, 'h900, 1, 0, 'hA00, 0,  1, 0, 1, 0, 'h900,  0, 0, 0, 0);
        tv[18] = mk(0, 0, 0, 'h000, 1, 0, 'hA00, 0,  0, 1, 1, 0, 'hA00,  1, 0, 0, 0);
        tv[19] = mk(0, 0, 0, 'h000, 0, 0, 'h000, 0,  0, 0, 0, 0, 'h000,  0, 1, 0, 0);
        tv[20] = mk(0, 0, 0, 'h000, 0, 0, 'h000, 0,  0, 0, 0, 0, 'h000,  0, 0, 1, 0);
        tv[21] = mk(0, 0, 0, 'h000, 0, 0, 'h000, 0,  0, 0, 0, 0, 'h000,  0, 0, 0, 1);
        vz = tv[12];

        Rst = 1'b1; CoreReq = 1'b0; CoreWrEn = 1'b0; HostReq = 1'b0; HostWrEn = 1'b0;
        HostLock = 1'b0; CoreAddr = '0; HostAddr = '0; CoreWrData = '0; HostWrData = '0;
        CoreByteEn = 4'hF; HostByteEn = 4'h3; MemRspData = '0;
        @(posedge Clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            Rst = tv[i].rst; CoreReq = tv[i].creq; CoreWrEn = tv[i].cwe;
            CoreAddr = tv[i].caddr; CoreWrData = tv[i].caddr ^ 32'hC000_0000;
            HostReq = tv[i].hreq; HostWrEn = tv[i].hwe; HostAddr = tv[i].haddr;
            HostWrData = tv[i].haddr ^ 32'hB000_0000; HostLock = tv[i].hlock;
            step(1, tv[i]);
        end

        // Lock streak: 8 host, 1 forced core, 8 host; then plain alternation.
        CoreReq = 1'b1; HostReq = 1'b1; CoreWrEn = 1'b0; HostWrEn = 1'b0;
        HostLock = 1'b1;
        for (int k = 0; k < 17; k++) begin
            CoreAddr = 32'h1000 + 32'(k * 4); HostAddr = 32'h2000 + 32'(k * 4);
            vz.e_crdy = (k == 8); vz.e_hrdy = (k != 8);
            step(2, vz);
        end
        HostLock = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vz.e_crdy = (k % 2 == 0); vz.e_hrdy = (k % 2 == 1);
            step(2, vz);
        end

        c_held = 1'b0;
        h_held = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!c_held) begin
                CoreReq = ($urandom_range(3) != 0); CoreWrEn = ($urandom_range(2) == 0);
                CoreAddr = $urandom() & 32'hFFFF_FFFC; CoreWrData = $urandom();
                CoreByteEn = 4'($urandom_range(15));
            end
            if (!h_held) begin
                HostReq = ($urandom_range(3) != 0); HostWrEn = ($urandom_range(2) == 0);
                HostAddr = $urandom() & 32'hFFFF_FFFC; HostWrData = $urandom();
                HostByteEn = 4'($urandom_range(15));
            end
            if ($urandom_range(15) == 0) HostLock = ~HostLock;
            Rst = ($urandom_range(79) == 0);
            step(0, vz);
            c_held = CoreReq && !g_core;
            h_held = HostReq && !g_host;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
